mxint_accumulator: RTL

// - Sums IN_DEPTH consecutive MxInt blocks element-wise into one MxInt block.
// - Aligns all blocks to the largest shared exponent seen so far in the group.
// - Sits directly upstream of mxint_cast: reduces partial dot-product blocks, and cast then renormalises the widened result.

---
 rtl/mxint_accumulator.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mxint_accumulator.sv
// mxint_accumulator
//
// Sums IN_DEPTH consecutive MxInt blocks element-wise into one MxInt block.
// All blocks in a group are aligned to the largest shared exponent seen so far,
// so the running sum always carries the group maximum exponent. The widened
// result is intended to feed mxint_cast for renormalisation.
//
// Ports:
//   clk             in   single clock, all logic on posedge
//   rst             in   synchronous active-low reset
//   mdata_in        in   BLOCK_SIZE packed signed mantissas, lane i at [i*IN_MAN_WIDTH +: IN_MAN_WIDTH]
//   edata_in        in   signed shared exponent of the input block
//   data_in_valid   in   input handshake
//   data_in_ready   out  input handshake
//   mdata_out       out  BLOCK_SIZE packed signed accumulated mantissas (OUT_MAN_WIDTH each)
//   edata_out       out  signed accumulated shared exponent
//   data_out_valid  out  output handshake
//   data_out_ready  in   output handshake
//
// Configuration:
//   MXINT_ACC_ROUND_EN  when defined, every right shift by s>0 rounds half up
//                       (adds 2^(s-1) first); shifts of OUT_MAN_WIDTH or more
//                       give 0. When undefined, shifts truncate toward -inf.

module mxint_accumulator #(
    parameter int IN_MAN_WIDTH = 8,
    parameter int IN_EXP_WIDTH = 4,
    parameter int BLOCK_SIZE   = 4,
    parameter int IN_DEPTH     = 4
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic [IN_MAN_WIDTH*BLOCK_SIZE-1:0]                      mdata_in,
    input  logic [IN_EXP_WIDTH-1:0]                                 edata_in,
    input  logic                                                    data_in_valid,
    output logic                                                    data_in_ready,
    output logic [(IN_MAN_WIDTH+$clog2(IN_DEPTH))*BLOCK_SIZE-1:0]   mdata_out,
    output logic [IN_EXP_WIDTH-1:0]                                 edata_out,
    output logic                                                    data_out_valid,
    input  logic                                                    data_out_ready
);

    localparam int OUT_MAN_WIDTH = IN_MAN_WIDTH + $clog2(IN_DEPTH);
    localparam int OUT_EXP_WIDTH = IN_EXP_WIDTH;
    localparam int CNT_WIDTH     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int DIFF_WIDTH    = IN_EXP_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(IN_DEPTH - 1);

    logic [CNT_WIDTH-1:0]             count;
    logic signed [OUT_MAN_WIDTH-1:0]  acc_man  [BLOCK_SIZE];
    logic signed [OUT_MAN_WIDTH-1:0]  next_man [BLOCK_SIZE];
    logic signed [OUT_MAN_WIDTH-1:0]  in_ext   [BLOCK_SIZE];
    logic signed [OUT_EXP_WIDTH-1:0]  acc_exp;
    logic signed [OUT_EXP_WIDTH-1:0]  next_exp;
    logic                             out_valid;
    logic                             accept;
    logic signed [DIFF_WIDTH-1:0]     exp_diff;
    logic [DIFF_WIDTH-1:0]            shift_acc;
    logic [DIFF_WIDTH-1:0]            shift_in;

    // Arithmetic right shift used for exponent alignment. Amounts at or beyond
    // the mantissa width collapse to the sign fill (or 0 when rounding, since
    // the half-LSB bias can never reach a full output LSB there).
    function automatic logic signed [OUT_MAN_WIDTH-1:0] shift_right(
        input logic signed [OUT_MAN_WIDTH-1:0] value,
        input logic [DIFF_WIDTH-1:0]           amount
    );
        int sh;
        logic signed [OUT_MAN_WIDTH-1:0] result;
`ifdef MXINT_ACC_ROUND_EN
        logic signed [OUT_MAN_WIDTH:0] wide;
        sh   = int'(amount);
        wide = {value[OUT_MAN_WIDTH-1], value};
        if (sh == 0) begin
            result = value;
        end else if (sh >= OUT_MAN_WIDTH) begin
            result = '0;
        end else begin
            // One extra bit keeps the rounding bias from overflowing.
            wide   = wide + ({{OUT_MAN_WIDTH{1'b0}}, 1'b1} << (sh - 1));
            wide   = wide >>> sh;
            result = wide[OUT_MAN_WIDTH-1:0];
        end
`else
        sh = int'(amount);
        if (sh >= OUT_MAN_WIDTH) begin
            result = {OUT_MAN_WIDTH{value[OUT_MAN_WIDTH-1]}};
        end else begin
            result = value >>> sh;
        end
`endif
        return result;
    endfunction

    assign data_in_ready  = rst && (!out_valid || data_out_ready);
    assign accept         = data_in_valid && data_in_ready;
    assign data_out_valid = out_valid;
    assign edata_out      = acc_exp;

    // Exponent difference is taken one bit wider so it never wraps; a positive
    // difference realigns the accumulator, otherwise the input is shifted.
    always_comb begin
        exp_diff  = {edata_in[IN_EXP_WIDTH-1], edata_in} - {acc_exp[OUT_EXP_WIDTH-1], acc_exp};
        shift_acc = '0;
        shift_in  = '0;
        if (exp_diff > 0) begin
            shift_acc = exp_diff;
        end else begin
            shift_in = -exp_diff;
        end
    end

    // Next accumulator value for an accepted block.
    always_comb begin
        next_exp = acc_exp;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            in_ext[i]   = OUT_MAN_WIDTH'(signed'(mdata_in[i*IN_MAN_WIDTH +: IN_MAN_WIDTH]));
            next_man[i] = acc_man[i];
        end
        if (count == '0) begin
            next_exp = edata_in;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                next_man[i] = in_ext[i];
            end
        end else if (exp_diff > 0) begin
            next_exp = edata_in;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                next_man[i] = shift_right(acc_man[i], shift_acc) + in_ext[i];
            end
        end else begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                next_man[i] = acc_man[i] + shift_right(in_ext[i], shift_in);
            end
        end
    end

    // Accumulator, group counter and output-valid flag. A completing block
    // takes precedence over a pop so back-to-back groups need no bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= '0;
            acc_exp   <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                acc_man[i] <= '0;
            end
        end else begin
            if (accept) begin
                acc_exp <= next_exp;
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    acc_man[i] <= next_man[i];
                end
                if (count == LAST_COUNT) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (accept && (count == LAST_COUNT)) begin
                out_valid <= 1'b1;
            end else if (data_out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Output mantissas are the accumulator lanes packed side by side.
    always_comb begin
        mdata_out = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            mdata_out[i*OUT_MAN_WIDTH +: OUT_MAN_WIDTH] = acc_man[i];
        end
    end

endmodule
